// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes, sequencer states and ALU selects.
// Opcode to ALU-operation and register-write decode helpers live here too.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_MOV  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_NOT  = 4'h8,
    OP_SHL  = 4'h9,
    OP_JMP  = 4'hA,
    OP_JZ   = 4'hB,
    OP_JNZ  = 4'hC,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_FETCH2 = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5,
    ALU_NOT  = 3'd6,
    ALU_SHL  = 3'd7
  } alu_op_t;

  function automatic alu_op_t alu_op_of(input opcode_t opcode);
    case (opcode)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_NOT:  return ALU_NOT;
      OP_SHL:  return ALU_SHL;
      default: return ALU_PASS;
    endcase
  endfunction

  // LDI through SHL are the only instructions that write a register (and Z).
  function automatic logic writes_reg(input opcode_t opcode);
    return (opcode >= OP_LDI) && (opcode <= OP_SHL);
  endfunction

endpackage

// File: rtl/control_unit_alu8.sv
// Combinational 8-bit ALU; a = R[rd], b = R[rs]. Carry and borrow are discarded.
module alu8
  import cpu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  alu_op_t    op,
  output logic [7:0] result
);

  always_comb begin
    result = b;
    case (op)
      ALU_PASS: result = b;
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOT:  result = ~b;
      ALU_SHL:  result = {b[6:0], 1'b0};
      default:  result = b;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving the register file.
// Define CU_BRANCH_EN to enable JZ/JNZ; otherwise opcodes B/C run as 1-byte NOPs.
module control_unit
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [7:0]          imem_data,
  output logic [2:0]          rf_read_addr1,
  output logic [2:0]          rf_read_addr2,
  input  logic [7:0]          rf_read_data1,
  input  logic [7:0]          rf_read_data2,
  output logic                rf_write_en,
  output logic [2:0]          rf_write_addr,
  output logic [7:0]          rf_write_data,
  output logic [PC_WIDTH-1:0] pc,
  output logic                zero_flag,
  output logic                halted
);

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pc_next;
  logic [7:0]          ir, opr;
  logic                z;
  opcode_t             opcode;
  logic [7:0]          alu_result;
  logic                needs_operand;
  logic                take_jump;

  assign opcode        = opcode_t'(ir[7:4]);
  assign rf_read_addr1 = {1'b0, ir[3:2]};
  assign rf_read_addr2 = {1'b0, ir[1:0]};
  assign rf_write_addr = {1'b0, ir[3:2]};
  assign imem_addr     = pc;
  assign zero_flag     = z;
  assign halted        = (state == S_HALT);

  alu8 u_alu (
    .a      (rf_read_data1),
    .b      (rf_read_data2),
    .op     (alu_op_of(opcode)),
    .result (alu_result)
  );

  // Branch opcodes only fetch an operand and load pc when branching is built in.
  always_comb begin
    needs_operand = 1'b0;
    take_jump     = 1'b0;
    case (opcode)
      OP_LDI: needs_operand = 1'b1;
      OP_JMP: begin
        needs_operand = 1'b1;
        take_jump     = 1'b1;
      end
`ifdef CU_BRANCH_EN
      OP_JZ: begin
        needs_operand = 1'b1;
        take_jump     = z;
      end
      OP_JNZ: begin
        needs_operand = 1'b1;
        take_jump     = ~z;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    rf_write_en   = 1'b0;
    rf_write_data = 8'h00;
    case (state)
      S_FETCH: begin
        state_next = S_DECODE;
        pc_next    = pc + PC_WIDTH'(1);
      end
      S_DECODE: begin
        if (opcode == OP_HALT)  state_next = S_HALT;
        else if (needs_operand) state_next = S_FETCH2;
        else                    state_next = S_EXEC;
      end
      S_FETCH2: begin
        state_next = S_EXEC;
        pc_next    = pc + PC_WIDTH'(1);
      end
      S_EXEC: begin
        state_next = S_FETCH;
        if (writes_reg(opcode)) begin
          rf_write_en   = 1'b1;
          rf_write_data = (opcode == OP_LDI) ? opr : alu_result;
        end
        if (take_jump) pc_next = PC_WIDTH'(opr);
      end
      S_HALT: ;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= 8'h00;
      opr   <= 8'h00;
      z     <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == S_FETCH)  ir  <= imem_data;
      if (state == S_FETCH2) opr <= imem_data;
      if (rf_write_en)       z   <= (rf_write_data == 8'h00);
    end
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU, sitting directly upstream of the register file. It fetches instruction bytes from a combinational instruction ROM, decodes them, and drives the register file read addresses and write port. It computes results with an internal 8-bit ALU, maintains the program counter and zero flag, and stops on HALT.

## Interface
Parameters:
- PC_WIDTH, 8, program counter and instruction-address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- imem_addr  out  PC_WIDTH  instruction ROM address; equals pc.
- imem_data  in  8  instruction ROM byte; combinational, valid in the same cycle.
- rf_read_addr1  out  3  register file port 1 address, {1'b0, rd}.
- rf_read_addr2  out  3  register file port 2 address, {1'b0, rs}.
- rf_read_data1  in  8  R[rd], combinational.
- rf_read_data2  in  8  R[rs], combinational.
- rf_write_en  out  1  register write strobe; high for exactly one EXEC cycle.
- rf_write_addr  out  3  write address, {1'b0, rd}.
- rf_write_data  out  8  write data: ALU result or immediate.
- pc  out  PC_WIDTH  current program counter.
- zero_flag  out  1  Z flag.
- halted  out  1  high while in HALT.

## Operation
- Instruction byte: opcode = ir[7:4], rd = ir[3:2], rs = ir[1:0].
- Opcodes (rd = rd op rs unless noted):
  - 0 NOP.
  - 1 LDI rd,#imm8 (2 bytes).
  - 2 MOV rd = rs.
  - 3 ADD.
  - 4 SUB.
  - 5 AND.
  - 6 OR.
  - 7 XOR.
  - 8 NOT: rd = ~rs.
  - 9 SHL: rd = rs << 1, LSB 0.
  - A JMP #addr (2 bytes).
  - B JZ #addr.
  - C JNZ #addr.
  - F HALT.
  - D and E execute as NOP.
- Arithmetic is mod 256. Carry and borrow are discarded; no carry flag.
- Z is updated on every register write (opcodes 1–9): Z = (rf_write_data == 0). All other instructions hold Z.
- State machine:
  - FETCH: ir <= imem_data; pc <= pc+1; go to DECODE.
  - DECODE:
    - Opcode 1/A/B/C: go to FETCH2.
    - Opcode F: go to HALT.
    - Otherwise: go to EXEC.
  - FETCH2: opr <= imem_data; pc <= pc+1; go to EXEC.
  - EXEC:
    - Opcodes 1–9: rf_write_en = 1.
    - JMP: pc <= opr.
    - JZ: pc <= opr if Z = 1.
    - JNZ: pc <= opr if Z = 0.
    - Then go to FETCH.
  - HALT: terminal. Outputs are held, no writes occur, and pc is frozen. Only rst_n exits this state.
- rf_read_addr1/2 and rf_write_addr are decoded from ir in every state. Bit 2 is always 0.
- pc wraps from 0xFF to 0x00 on increment, including in FETCH2.

## Timing
- Reset values: state = FETCH, pc = 0, ir = 0, opr = 0, Z = 0, halted = 0, rf_write_en = 0, rf_write_data = 0.
- Outputs are combinational from the state, ir, and opr registers, and are stable for a whole state.
- Cycles per instruction:
  - 1-byte ALU/MOV/NOP: 3 (FETCH, DECODE, EXEC).
  - LDI/JMP/JZ/JNZ: 4.
  - HALT: 2 cycles to reach HALT.
- A register write lands on the rising edge that ends EXEC. The next instruction's DECODE sees the updated value (no hazard).
- An instruction that reads and writes the same register (e.g. ADD R1,R1) uses the pre-write value.
- Reset asserted mid-instruction aborts it immediately: no write, no pc change beyond reset to 0.
- A 2-byte instruction at 0xFF fetches its operand from 0x00.

## Configuration
- CU_BRANCH_EN defined: JZ/JNZ behave as specified.
- CU_BRANCH_EN undefined:
  - Opcodes B/C decode as 1-byte NOPs (DECODE to EXEC, no FETCH2, no pc load).
  - The branch compare logic is not compiled.
  - JMP is unaffected.

## Structure
- Shared package cpu_pkg holds:
  - Opcode constants (OP_NOP through OP_HALT).
  - State encodings (S_FETCH, S_DECODE, S_FETCH2, S_EXEC, S_HALT).
  - ALU operation select codes.
- Sub-module alu8 (combinational): inputs a, b, op; output result[7:0]. It is instantiated once, fed from rf_read_data1/rf_read_data2.
- control_unit holds the FSM, pc/ir/opr/Z registers, and write-data muxing (ALU result vs opr).

## Test plan
- Reset release, ROM = {0x10 (LDI R0), 0x05, 0xF0} -> R0 write 0x05 in cycle 4, Z = 0; halted = 1 by cycle 6; pc frozen at 3.
- LDI R1,#0xFF; LDI R2,#0x01; ADD R1,R2 (0x36) -> write R1 = 0x00, Z = 1, and the ADD takes exactly 3 cycles.
- SUB underflow: R0 = 0x00, R1 = 0x01, SUB R0,R1 (0x41) -> R0 = 0xFF, Z = 0. SHL of 0x80 -> 0x00, Z = 1.
- JZ taken and not taken (CU_BRANCH_EN defined):
  - Z = 1, JZ 0x20 -> pc = 0x20.
  - Z = 0 -> pc = next address.
  - Repeat with the macro undefined: opcode B takes 3 cycles and the following byte executes as an instruction.
- Wrap: JMP 0xFF, ROM[0xFF] = 0x10, ROM[0x00] = 0x7A -> R0 = 0x7A, pc = 0x01 after FETCH2.
- Assert rst_n low during EXEC of ADD -> rf_write_en = 0 immediately, no register change; after release, fetch restarts at 0x00.
